// File: rtl/univ_reg_pkg.sv
// univ_reg_pkg: shared mode encodings for the universal register
package univ_reg_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/univ_reg_next.sv
// univ_reg_next: combinational next value and next carry/shift-out for every mode
module univ_reg_next
    import univ_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  q_i,
    input  logic              cout_i,
    input  logic [WIDTH-1:0]  d_i,
    input  logic              sin_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [WIDTH-1:0]  nxt_q_o,
    output logic              nxt_cout_o
);

    logic [WIDTH:0] inc_w;
    logic [WIDTH:0] dec_w;

    // Arithmetic is done one bit wider so the top bit is the carry (INC) or borrow (DEC)
    assign inc_w = {1'b0, q_i} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_w = {1'b0, q_i} - {{WIDTH{1'b0}}, 1'b1};

    // Select the per-mode result; HOLD keeps both Q and the flag
    always_comb begin
        nxt_q_o    = q_i;
        nxt_cout_o = cout_i;
        case (mode_i)
            MODE_LOAD: begin
                nxt_q_o    = d_i;
                nxt_cout_o = 1'b0;
            end
            MODE_SHL: begin
                nxt_q_o    = {q_i[WIDTH-2:0], sin_i};
                nxt_cout_o = q_i[WIDTH-1];
            end
            MODE_SHR: begin
                nxt_q_o    = {sin_i, q_i[WIDTH-1:1]};
                nxt_cout_o = q_i[0];
            end
            MODE_ROL: begin
                nxt_q_o    = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                nxt_cout_o = q_i[WIDTH-1];
            end
            MODE_ROR: begin
                nxt_q_o    = {q_i[0], q_i[WIDTH-1:1]};
                nxt_cout_o = q_i[0];
            end
            MODE_INC: begin
                nxt_q_o    = inc_w[WIDTH-1:0];
                nxt_cout_o = inc_w[WIDTH];
            end
            MODE_DEC: begin
                nxt_q_o    = dec_w[WIDTH-1:0];
                nxt_cout_o = dec_w[WIDTH];
            end
            default: begin
                nxt_q_o    = q_i;
                nxt_cout_o = cout_i;
            end
        endcase
    end

endmodule

// File: rtl/univ_reg.sv
// univ_reg: parametrised load/shift/rotate/count register with carry and zero flags
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  D,
    input  logic              sin,
    output logic [WIDTH-1:0]  Q,
    output logic              cout,
    output logic              zero
);

    localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             cout_q;
    logic             cout_d;

    univ_reg_next #(.WIDTH(WIDTH)) u_next (
        .q_i        (q_q),
        .cout_i     (cout_q),
        .d_i        (D),
        .sin_i      (sin),
        .mode_i     (mode),
        .nxt_q_o    (q_d),
        .nxt_cout_o (cout_d)
    );

    // Reset beats everything; otherwise update only when enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q    <= RST_Q;
            cout_q <= 1'b0;
        end else if (en) begin
            q_q    <= q_d;
            cout_q <= cout_d;
        end
    end

    assign Q    = q_q;
    assign cout = cout_q;
    assign zero = (q_q == '0);

endmodule

// File: tb/tb_univ_reg.sv
// tb_univ_reg: directed checks of univ_reg at WIDTH=8 and WIDTH=4/RESET_VAL=5
module tb_univ_reg;
    import univ_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n_a, en_a, sin_a;
    logic [2:0] mode_a;
    logic [7:0] d_a, q_a;
    logic       cout_a, zero_a;
    logic       rst_n_b, en_b, sin_b;
    logic [2:0] mode_b;
    logic [3:0] d_b, q_b;
    logic       cout_b, zero_b;
    int         total = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    univ_reg #(.WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .en(en_a), .mode(mode_a), .D(d_a),
        .sin(sin_a), .Q(q_a), .cout(cout_a), .zero(zero_a)
    );

    univ_reg #(.WIDTH(4), .RESET_VAL(32'd5)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .en(en_b), .mode(mode_b), .D(d_b),
        .sin(sin_b), .Q(q_b), .cout(cout_b), .zero(zero_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op_a(input logic [2:0] m, input logic [7:0] d, input logic s);
        mode_a = m;
        d_a    = d;
        sin_a  = s;
        tick();
    endtask

    task automatic op_b(input logic [2:0] m, input logic [3:0] d);
        mode_b = m;
        d_b    = d;
        tick();
    endtask

    initial begin
        rst_n_a = 1'b0; en_a = 1'b1; mode_a = MODE_LOAD; d_a = 8'hA5; sin_a = 1'b0;
        rst_n_b = 1'b0; en_b = 1'b1; mode_b = MODE_INC;  d_b = 4'h0;  sin_b = 1'b0;
        repeat (2) tick();
        check("rst_q", 32'(q_a), 32'h00);
        check("rst_cout", 32'(cout_a), 32'h0);
        check("rst_zero", 32'(zero_a), 32'h1);
        check("b_rst_q", 32'(q_b), 32'h5);
        rst_n_a = 1'b1;
        op_a(MODE_LOAD, 8'hA5, 1'b0);
        check("load_q", 32'(q_a), 32'hA5);
        check("load_zero", 32'(zero_a), 32'h0);
        en_a = 1'b0;
        repeat (3) op_a(MODE_LOAD, 8'h3C, 1'b0);
        check("en0_q", 32'(q_a), 32'hA5);
        check("en0_cout", 32'(cout_a), 32'h0);
        en_a = 1'b1;
        op_a(MODE_SHL, 8'h00, 1'b1);
        check("shl_q", 32'(q_a), 32'h4B);
        check("shl_cout", 32'(cout_a), 32'h1);
        op_a(MODE_SHR, 8'h00, 1'b0);
        check("shr0_q", 32'(q_a), 32'h25);
        check("shr0_cout", 32'(cout_a), 32'h1);
        op_a(MODE_SHR, 8'h00, 1'b1);
        check("shr1_q", 32'(q_a), 32'h92);
        check("shr1_cout", 32'(cout_a), 32'h1);
        op_a(MODE_LOAD, 8'h81, 1'b0);
        check("load81_cout", 32'(cout_a), 32'h0);
        op_a(MODE_ROL, 8'h00, 1'b0);
        check("rol_q", 32'(q_a), 32'h03);
        check("rol_cout", 32'(cout_a), 32'h1);
        op_a(MODE_ROR, 8'h00, 1'b0);
        check("ror1_q", 32'(q_a), 32'h81);
        check("ror1_cout", 32'(cout_a), 32'h1);
        op_a(MODE_ROR, 8'h00, 1'b0);
        check("ror2_q", 32'(q_a), 32'hC0);
        check("ror2_cout", 32'(cout_a), 32'h1);
        op_a(MODE_LOAD, 8'hFE, 1'b0);
        op_a(MODE_INC, 8'h00, 1'b0);
        check("inc1_q", 32'(q_a), 32'hFF);
        check("inc1_cout", 32'(cout_a), 32'h0);
        op_a(MODE_INC, 8'h00, 1'b0);
        check("inc2_q", 32'(q_a), 32'h00);
        check("inc2_cout", 32'(cout_a), 32'h1);
        check("inc2_zero", 32'(zero_a), 32'h1);
        op_a(MODE_HOLD, 8'h55, 1'b1);
        check("hold_q", 32'(q_a), 32'h00);
        check("hold_cout", 32'(cout_a), 32'h1);
        op_a(MODE_DEC, 8'h00, 1'b0);
        check("dec1_q", 32'(q_a), 32'hFF);
        check("dec1_cout", 32'(cout_a), 32'h1);
        check("dec1_zero", 32'(zero_a), 32'h0);
        op_a(MODE_DEC, 8'h00, 1'b0);
        check("dec2_q", 32'(q_a), 32'hFE);
        check("dec2_cout", 32'(cout_a), 32'h0);
        rst_n_a = 1'b0;
        op_a(MODE_SHL, 8'h00, 1'b1);
        check("midshift_rst_q", 32'(q_a), 32'h00);
        check("midshift_rst_cout", 32'(cout_a), 32'h0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        op_b(MODE_LOAD, 4'hE);
        check("b_load_q", 32'(q_b), 32'hE);
        op_b(MODE_INC, 4'h0);
        check("b_inc_q", 32'(q_b), 32'hF);
        check("b_inc_cout", 32'(cout_b), 32'h0);
        rst_n_b = 1'b0;
        op_b(MODE_INC, 4'h0);
        check("b_rstwin_q", 32'(q_b), 32'h5);
        check("b_rstwin_cout", 32'(cout_b), 32'h0);
        rst_n_b = 1'b1;
        repeat (4) op_b(MODE_HOLD, 4'hA);
        check("b_hold_q", 32'(q_b), 32'h5);
        check("b_hold_cout", 32'(cout_b), 32'h0);
        check("b_hold_zero", 32'(zero_b), 32'h0);
        op_b(MODE_LOAD, 4'hF);
        op_b(MODE_INC, 4'h0);
        check("b_wrap_q", 32'(q_b), 32'h0);
        check("b_wrap_cout", 32'(cout_b), 32'h1);
        check("b_wrap_zero", 32'(zero_b), 32'h1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
